// File: rtl/cic_upsample_interp_pkg.sv
// Shared types and elaboration helpers for the CIC interpolator.
package cic_pkg;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic int slot_w(input int r);
    return (r <= 2) ? 1 : $clog2(r);
  endfunction

  function automatic int min_guard(input int k, input int r, input int n);
    return k * $clog2(r * n) - $clog2(r);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator stage: accumulates only on valid input, valid travels with the data.
module cic_integrator_stage #(
  parameter int WO = 25
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_in,
  input  logic [WO-1:0] din,
  output logic          vld_out,
  output logic [WO-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      vld_out <= 1'b0;
    end else begin
      vld_out <= vld_in;
      if (vld_in) acc <= acc + din;
    end
  end

endmodule

// File: rtl/cic_upsample_interp.sv
// K-stage CIC interpolator: low-rate combs, zero-stuff by R, high-rate integrators.
// Optional CIC_GAIN_NORM_EN adds a rounded right shift by GAIN_SHIFT and one register stage.
module cic_upsample_interp
  import cic_pkg::*;
#(
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int N          = 1,
  parameter int R          = 8,
  parameter int K          = 2,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              data_i_en,
  output logic                              data_i_ready,
  input  logic signed [width_W-1:0]         data_i,
  output logic                              data_o_en,
  output logic signed [width_H+width_W-1:0] data_o
);

  localparam int WO = width_H + width_W;
  localparam int SW = slot_w(R);
  localparam logic [SW-1:0] SLOT_LAST = SW'(R - 1);

  if (width_H < min_guard(K, R, N) || K < 1 || K > 6 || R < 2 ||
      GAIN_SHIFT < 0 || GAIN_SHIFT >= WO) begin : g_param_chk
    $error("cic_upsample_interp: illegal parameter set");
  end

  // ---- comb section (input rate) ----
  logic [K-1:0][N-1:0][WO-1:0] dly;
  logic [K:0][WO-1:0]          cx;
  logic [WO-1:0]               stuff_reg;
  logic                        accept;

  assign accept = data_i_en && data_i_ready;

  always_comb begin
    cx    = '0;
    cx[0] = {{width_H{data_i[width_W-1]}}, data_i};
    for (int k = 0; k < K; k++) cx[k+1] = cx[k] - dly[k][N-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly       <= '0;
      stuff_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < K; k++) begin
        dly[k][0] <= cx[k];
        for (int j = 1; j < N; j++) dly[k][j] <= dly[k][j-1];
      end
      stuff_reg <= cx[K];
    end
  end

  // ---- slot sequencer ----
  state_t        state, state_nx;
  logic [SW-1:0] slot, slot_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    slot_nx      = slot;
    data_i_ready = 1'b1;
    case (state)
      IDLE: if (data_i_en) begin
        state_nx = EMIT;
        slot_nx  = '0;
      end
      EMIT: begin
        data_i_ready = (slot == SLOT_LAST);
        if (slot == SLOT_LAST) begin
          slot_nx = '0;
          if (!data_i_en) state_nx = IDLE;
        end else begin
          slot_nx = slot + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- integrator section (output rate); bubbles freeze every stage ----
  logic [K:0]         vld_pipe;
  logic [K:0][WO-1:0] int_pipe;

  assign vld_pipe[0] = (state == EMIT);
  assign int_pipe[0] = (slot == '0) ? stuff_reg : '0;

  for (genvar k = 0; k < K; k++) begin : g_int
    cic_integrator_stage #(.WO(WO)) u_int (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (vld_pipe[k]),
      .din     (int_pipe[k]),
      .vld_out (vld_pipe[k+1]),
      .acc     (int_pipe[k+1])
    );
  end

`ifdef CIC_GAIN_NORM_EN
  localparam logic [WO-1:0] RND = WO'((64'd1 << GAIN_SHIFT) >> 1);
  logic signed [WO-1:0] rounded;

  assign rounded = $signed(int_pipe[K]) + $signed(RND);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o    <= '0;
      data_o_en <= 1'b0;
    end else begin
      data_o_en <= vld_pipe[K];
      if (vld_pipe[K]) data_o <= rounded >>> GAIN_SHIFT;
    end
  end
`else
  assign data_o    = $signed(int_pipe[K]);
  assign data_o_en = vld_pipe[K];
`endif

endmodule

// File: tb/tb_cic_upsample_interp.sv
// Directed bench for cic_upsample_interp with R=4, K=2, N=1, W=20, H=5.
module tb_cic_upsample_interp;

  localparam int WO = 25;
  localparam int R  = 4;
`ifdef CIC_GAIN_NORM_EN
  localparam int GS  = 2;
  localparam int LAT = 4;
`else
  localparam int GS  = 0;
  localparam int LAT = 3;
`endif

  logic                 clk;
  logic                 rst;
  logic                 din_en;
  logic                 data_i_ready;
  logic signed [19:0]   din;
  logic                 data_o_en;
  logic signed [WO-1:0] data_o;

  int errs   = 0;
  int checks = 0;

  logic signed [WO-1:0] samp_q[$];
  logic signed [WO-1:0] out_q[$];
  int first_acc, first_out, drops, n_acc;

  cic_upsample_interp #(
    .width_H(5), .width_W(20), .N(1), .R(R), .K(2), .GAIN_SHIFT(GS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_i_en    (din_en),
    .data_i_ready (data_i_ready),
    .data_i       (din),
    .data_o_en    (data_o_en),
    .data_o       (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [WO-1:0] norm(input int v);
    logic signed [WO-1:0] t;
    t = WO'(v) + WO'((1 << GS) >> 1);
    return t >>> GS;
  endfunction

  function automatic int imp(input int i);
    if (i < 4) return i + 1;
    if (i < 8) return 7 - i;
    return 0;
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; din_en = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Drives samp_q honouring ready; optional idle gap before sample gap_at and
  // garbage data_i_en while not ready. Records every valid output.
  task automatic run_stream(input int gap_at, input int gap_len, input bit garbage, input int ncyc);
    int si, gap_left;
    si = 0; gap_left = gap_len;
    first_acc = -1; first_out = -1; drops = 0; n_acc = 0;
    out_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (data_o_en) begin
        out_q.push_back(data_o);
        if (first_out < 0) first_out = c;
      end else if (first_out >= 0 && out_q.size() < R * samp_q.size()) begin
        drops++;
      end
      if (data_i_ready && si < samp_q.size() && si == gap_at && gap_left > 0) begin
        din_en = 1'b0;
        gap_left--;
      end else if (data_i_ready && si < samp_q.size()) begin
        din_en = 1'b1;
        din    = samp_q[si][19:0];
        if (first_acc < 0) first_acc = c;
        si++; n_acc++;
      end else begin
        din_en = garbage && !data_i_ready;
        din    = 20'sd777;
      end
    end
    din_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din_en = 1'b0; din = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (data_o_en !== 1'b0) begin errs++; $display("FAIL reset_en: got %b want 0", data_o_en); end
    checks++; if (data_o !== '0) begin errs++; $display("FAIL reset_data: got %0d want 0", data_o); end
    checks++; if (data_i_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", data_i_ready); end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    pulse_reset();
    samp_q = '{1, 0, 0, 0, 0, 0};
    run_stream(-1, 0, 1'b0, 6 * R + LAT + 8);
    checks++; if (first_out - first_acc !== LAT) begin errs++; $display("FAIL impulse_latency: got %0d want %0d", first_out - first_acc, LAT); end
    checks++; if (out_q.size() !== 6 * R) begin errs++; $display("FAIL impulse_count: got %0d want %0d", out_q.size(), 6 * R); end
    checks++; if (drops !== 0) begin errs++; $display("FAIL impulse_contig: got %0d gaps want 0", drops); end
    for (int i = 0; i < out_q.size() && i < 6 * R; i++) begin
      checks++;
      if (out_q[i] !== norm(imp(i))) begin errs++; $display("FAIL impulse[%0d]: got %0d want %0d", i, out_q[i], norm(imp(i))); end
    end
  endtask

  task automatic test_step();
    pulse_reset();
    samp_q.delete();
    for (int i = 0; i < 10; i++) samp_q.push_back(WO'(100));
    run_stream(-1, 0, 1'b0, 10 * R + LAT + 8);
    checks++; if (drops !== 0) begin errs++; $display("FAIL step_contig: got %0d gaps want 0", drops); end
    checks++; if (out_q.size() !== 10 * R) begin errs++; $display("FAIL step_count: got %0d want %0d", out_q.size(), 10 * R); end
    for (int i = 0; i < out_q.size(); i++) begin
      int e;
      e = (i < 4) ? 100 * (i + 1) : 400;
      checks++;
      if (out_q[i] !== norm(e)) begin errs++; $display("FAIL step[%0d]: got %0d want %0d", i, out_q[i], norm(e)); end
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    samp_q = '{1, 0, 0, 0, 0};
    run_stream(1, 5, 1'b1, 5 * R + LAT + 16);
    checks++; if (n_acc !== 5) begin errs++; $display("FAIL stall_accepts: got %0d want 5", n_acc); end
    checks++; if (drops !== 5) begin errs++; $display("FAIL stall_gap: got %0d idle cycles want 5", drops); end
    checks++; if (out_q.size() !== 5 * R) begin errs++; $display("FAIL stall_count: got %0d want %0d", out_q.size(), 5 * R); end
    for (int i = 0; i < out_q.size() && i < 5 * R; i++) begin
      checks++;
      if (out_q[i] !== norm(imp(i))) begin errs++; $display("FAIL stall[%0d]: got %0d want %0d", i, out_q[i], norm(imp(i))); end
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    samp_q.delete();
    for (int i = 0; i < 10; i++) samp_q.push_back(-WO'(524288));
    run_stream(-1, 0, 1'b0, 10 * R + LAT + 8);
    checks++; if (out_q.size() !== 10 * R) begin errs++; $display("FAIL wrap_count: got %0d want %0d", out_q.size(), 10 * R); end
    for (int i = 0; i < out_q.size(); i++) begin
      int e;
      e = (i < 4) ? -524288 * (i + 1) : -2097152;
      checks++;
      if (out_q[i] !== norm(e)) begin errs++; $display("FAIL wrap[%0d]: got %0d want %0d", i, out_q[i], norm(e)); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    @(negedge clk); din_en = 1'b1; din = 20'sd5;
    @(negedge clk); din_en = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (data_o_en !== 1'b0) begin errs++; $display("FAIL midrst_en: got %b want 0", data_o_en); end
    checks++; if (data_o !== '0) begin errs++; $display("FAIL midrst_data: got %0d want 0", data_o); end
    checks++; if (data_i_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", data_i_ready); end
    rst = 1'b0;
    samp_q = '{1, 0, 0};
    run_stream(-1, 0, 1'b0, 3 * R + LAT + 8);
    checks++; if (first_out - first_acc !== LAT) begin errs++; $display("FAIL midrst_latency: got %0d want %0d", first_out - first_acc, LAT); end
    checks++; if (out_q.size() !== 3 * R) begin errs++; $display("FAIL midrst_count: got %0d want %0d", out_q.size(), 3 * R); end
    for (int i = 0; i < out_q.size() && i < 3 * R; i++) begin
      checks++;
      if (out_q[i] !== norm(imp(i))) begin errs++; $display("FAIL midrst[%0d]: got %0d want %0d", i, out_q[i], norm(imp(i))); end
    end
  endtask

  initial begin
    rst = 1'b1; din_en = 1'b0; din = '0;
    test_reset();
    test_impulse();
    test_step();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
